// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl
// ---------------------------------------------------------------------------
// Power sequencer and configuration shadow for a bank of NCH IO pads.
// On pwr_good the bank waits PWR_DLY cycles, raises ENABLE_H on every pad,
// holds HLD_H_N low for HOLD_DLY cycles and then enters RUN. A configuration
// write in RUN puts the target pad into hold: one cycle of hold, then the
// shadow is updated, then HOLD_DLY more cycles of hold. Writes made before
// RUN are applied to the shadow directly. Losing pwr_good sends the bank
// back to OFF from any state; the shadows survive.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   pwr_good   in   IO ring supplies stable (level)
//   cfg_valid  in   config write request
//   cfg_ready  out  write accepted when cfg_valid & cfg_ready at an edge
//   cfg_ch     in   CHW  target channel (codes >= NCH are accepted and dropped)
//   cfg_data   in   8    [2:0] DM, [3] SLOW, [4] VTRIP_SEL, [5] IB_MODE_SEL,
//                        [6] ANALOG_EN, [7] ANALOG_POL
//   tech_cfg   out  NCH*16  pad control, channel i at [16i+15:16i]
//   state      out  3    sequencer state
//   busy       out  1    high in every state except RUN
//
// Optional feature: define GPIO_BANK_CTRL_READBACK_EN to add
//   rd_ch      in   CHW  channel to read back
//   rd_data    out  8    shadow[rd_ch], combinational; 0 when rd_ch >= NCH
// ---------------------------------------------------------------------------
module gpio_bank_ctrl #(
  parameter  int         NCH      = 8,
  parameter  int         PWR_DLY  = 16,
  parameter  int         HOLD_DLY = 4,
  parameter  logic [2:0] DM_RST   = 3'b001,
  localparam int         CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwr_good,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [7:0]       cfg_data,
  output logic [NCH*16-1:0] tech_cfg,
  output logic [2:0]       state,
  output logic             busy
`ifdef GPIO_BANK_CTRL_READBACK_EN
  ,
  input  logic [CHW-1:0]   rd_ch,
  output logic [7:0]       rd_data
`endif
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAIT_PWR = 3'd1,
    ST_ENABLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_UPD_HOLD = 3'd4,
    ST_UPD_REL  = 3'd5
  } state_t;

  // Counters count 0..DLY-1, so the state is left on the edge where the
  // counter holds its last value.
  localparam logic [7:0]   PWR_LAST   = 8'(PWR_DLY - 1);
  localparam logic [7:0]   HOLD_LAST  = 8'(HOLD_DLY - 1);
  localparam logic [CHW:0] NCH_W      = (CHW + 1)'(NCH);
  localparam logic [7:0]   SHADOW_RST = {5'b00000, DM_RST};

  state_t         state_q;
  logic [7:0]     cnt_q;
  logic [CHW-1:0] tgt_q;
  logic [7:0]     dat_q;
  logic [7:0]     shadow_q [NCH];

  logic           en_s;
  logic           hld_all_s;
  logic           tgt_low_s;
  logic           pre_run_s;
  logic           pwr_lost_s;
  logic           ch_ok_s;
  logic           wr_acc_s;
  logic           sh_we_s;
  logic [CHW-1:0] sh_idx_s;
  logic [7:0]     sh_wd_s;

  // State decode: handshake readiness and bank-wide enable/hold levels.
  always_comb begin
    cfg_ready = 1'b0;
    en_s      = 1'b0;
    hld_all_s = 1'b0;
    tgt_low_s = 1'b0;
    pre_run_s = 1'b0;
    case (state_q)
      ST_OFF, ST_WAIT_PWR: begin
        cfg_ready = 1'b1;
        pre_run_s = 1'b1;
      end
      ST_ENABLE: begin
        cfg_ready = 1'b1;
        pre_run_s = 1'b1;
        en_s      = 1'b1;
      end
      ST_RUN: begin
        cfg_ready = 1'b1;
        en_s      = 1'b1;
        hld_all_s = 1'b1;
      end
      ST_UPD_HOLD, ST_UPD_REL: begin
        en_s      = 1'b1;
        hld_all_s = 1'b1;
        tgt_low_s = 1'b1;
      end
      default: begin
        cfg_ready = 1'b0;
        en_s      = 1'b0;
      end
    endcase
  end

  // OFF with pwr_good low is the resting state, not a loss event, so writes
  // made there still reach the shadow.
  assign pwr_lost_s = ~pwr_good & (state_q != ST_OFF);
  assign ch_ok_s    = ({1'b0, cfg_ch} < NCH_W);
  assign wr_acc_s   = cfg_valid & cfg_ready;

  // Single shadow write port: deferred update at the end of UPD_HOLD, or a
  // direct write before RUN. Power loss suppresses both.
  always_comb begin
    sh_we_s  = 1'b0;
    sh_idx_s = cfg_ch;
    sh_wd_s  = cfg_data;
    if (pwr_lost_s) begin
      sh_we_s = 1'b0;
    end else if (state_q == ST_UPD_HOLD) begin
      sh_we_s  = 1'b1;
      sh_idx_s = tgt_q;
      sh_wd_s  = dat_q;
    end else if (wr_acc_s && ch_ok_s && pre_run_s) begin
      sh_we_s = 1'b1;
    end else begin
      sh_we_s = 1'b0;
    end
  end

  // Sequencer, delay counter, captured update and channel shadows.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      cnt_q   <= 8'd0;
      tgt_q   <= '0;
      dat_q   <= 8'h00;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= SHADOW_RST;
      end
    end else begin
      if (pwr_lost_s) begin
        state_q <= ST_OFF;
        cnt_q   <= 8'd0;
      end else begin
        case (state_q)
          ST_OFF: begin
            if (pwr_good) begin
              state_q <= ST_WAIT_PWR;
              cnt_q   <= 8'd0;
            end
          end
          ST_WAIT_PWR: begin
            if (cnt_q == PWR_LAST) begin
              state_q <= ST_ENABLE;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          ST_ENABLE: begin
            if (cnt_q == HOLD_LAST) begin
              state_q <= ST_RUN;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          ST_RUN: begin
            // Out-of-range channels complete the handshake and are dropped.
            if (wr_acc_s && ch_ok_s) begin
              state_q <= ST_UPD_HOLD;
              tgt_q   <= cfg_ch;
              dat_q   <= cfg_data;
              cnt_q   <= 8'd0;
            end
          end
          ST_UPD_HOLD: begin
            state_q <= ST_UPD_REL;
            cnt_q   <= 8'd0;
          end
          ST_UPD_REL: begin
            if (cnt_q == HOLD_LAST) begin
              state_q <= ST_RUN;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: begin
            state_q <= ST_OFF;
            cnt_q   <= 8'd0;
          end
        endcase
      end
      for (int i = 0; i < NCH; i++) begin
        if (sh_we_s && (sh_idx_s == i[CHW-1:0])) begin
          shadow_q[i] <= sh_wd_s;
        end
      end
    end
  end

  // Per-channel pad control word; only the update target loses HLD_H_N.
  always_comb begin
    tech_cfg = '0;
    for (int i = 0; i < NCH; i++) begin
      tech_cfg[16*i + 0]  = hld_all_s & ~(tgt_low_s & (tgt_q == i[CHW-1:0]));
      tech_cfg[16*i + 1]  = en_s;
      tech_cfg[16*i + 2]  = 1'b0;
      tech_cfg[16*i + 3]  = en_s;
      tech_cfg[16*i + 4]  = en_s;
      tech_cfg[16*i + 5]  = en_s;
      tech_cfg[16*i + 6]  = shadow_q[i][5];
      tech_cfg[16*i + 7]  = shadow_q[i][4];
      tech_cfg[16*i + 8]  = shadow_q[i][3];
      tech_cfg[16*i + 9]  = 1'b0;
      tech_cfg[16*i + 10] = shadow_q[i][6];
      tech_cfg[16*i + 11] = 1'b0;
      tech_cfg[16*i + 12] = shadow_q[i][7];
      tech_cfg[16*i + 13 +: 3] = shadow_q[i][2:0];
    end
  end

  assign state = state_q;
  assign busy  = (state_q != ST_RUN);

`ifdef GPIO_BANK_CTRL_READBACK_EN
  // Shadow readback mux; unused codes read as zero.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      rd_data = (rd_ch == i[CHW-1:0]) ? shadow_q[i] : rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl. Six channels are used so that
// out-of-range channel codes (6, 7) are representable on the 3-bit cfg_ch.
module tb_gpio_bank_ctrl;

  localparam int NCH = 6;
  localparam int CHW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              pwr_good;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHW-1:0]    cfg_ch;
  logic [7:0]        cfg_data;
  logic [NCH*16-1:0] tech_cfg;
  logic [2:0]        state;
  logic              busy;
`ifdef GPIO_BANK_CTRL_READBACK_EN
  logic [CHW-1:0]    rd_ch;
  logic [7:0]        rd_data;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_sh [NCH];

  always #5 clk = ~clk;

  gpio_bank_ctrl #(
    .NCH(NCH), .PWR_DLY(16), .HOLD_DLY(4), .DM_RST(3'b001)
  ) dut (
    .clk(clk), .reset(reset), .pwr_good(pwr_good), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .tech_cfg(tech_cfg), .state(state), .busy(busy)
`ifdef GPIO_BANK_CTRL_READBACK_EN
    , .rd_ch(rd_ch), .rd_data(rd_data)
`endif
  );

  // Expected pad word for one channel from its shadow byte.
  function automatic logic [15:0] tc(input logic [7:0] sh, input logic en, input logic hld);
    logic [15:0] r;
    r = 16'h0000;
    r[0] = hld; r[1] = en; r[3] = en; r[4] = en; r[5] = en;
    r[6] = sh[5]; r[7] = sh[4]; r[8] = sh[3]; r[10] = sh[6]; r[12] = sh[7];
    r[15:13] = sh[2:0];
    return r;
  endfunction

  // Expected whole bank; low_ch is the channel held low (-1 for none).
  function automatic logic [NCH*16-1:0] exp_tc(input logic en, input logic hld, input int low_ch);
    logic [NCH*16-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[16*i +: 16] = tc(exp_sh[i], en, hld && (i != low_ch));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pwr_good = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_data = 8'hFF;
    step(); step();
    for (int i = 0; i < NCH; i++) exp_sh[i] = 8'h01;
    n_checks++;
    if ({state, busy, cfg_ready} !== {3'd0, 1'b1, 1'b1}) $display("FAIL reset_ctrl state/busy/ready got %0d/%0b/%0b want 0/1/1", state, busy, cfg_ready);
    else n_pass++;
    n_checks++;
    if (tech_cfg !== {6{16'h2000}}) $display("FAIL reset_tech got %h want %h", tech_cfg, {6{16'h2000}});
    else n_pass++;
    cfg_valid = 1'b0; pwr_good = 1'b0;
  endtask

  task automatic test_powerup();
    logic [2:0] st;
    reset = 1'b0; pwr_good = 1'b1; cfg_valid = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      step();
      st = (n <= 16) ? 3'd1 : (n <= 20) ? 3'd2 : 3'd3;
      n_checks++;
      if ({state, busy} !== {st, (n < 21)} || tech_cfg !== exp_tc(n >= 17, n >= 21, -1))
        $display("FAIL powerup cycle %0d state=%0d busy=%0b tech=%h want state=%0d busy=%0b tech=%h",
                 n, state, busy, tech_cfg, st, (n < 21), exp_tc(n >= 17, n >= 21, -1));
      else n_pass++;
    end
  endtask

  task automatic test_update();
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_data = 8'h0E;
    n_checks++;
    if (cfg_ready !== 1'b1) $display("FAIL upd_ready_run got %b want 1", cfg_ready);
    else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 2) exp_sh[3] = 8'h0E;
      n_checks++;
      if (state !== ((k == 1) ? 3'd4 : (k <= 5) ? 3'd5 : 3'd3) || cfg_ready !== (k == 6) ||
          tech_cfg !== exp_tc(1'b1, 1'b1, (k <= 5) ? 3 : -1))
        $display("FAIL update k=%0d state=%0d ready=%0b tech=%h want tech=%h",
                 k, state, cfg_ready, tech_cfg, exp_tc(1'b1, 1'b1, (k <= 5) ? 3 : -1));
      else n_pass++;
      if (k == 1) cfg_valid = 1'b0;
    end
    n_checks++;
    if (tech_cfg[63:48] !== 16'hC13B) $display("FAIL upd_ch3_word got %h want c13b", tech_cfg[63:48]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int low;
    logic [2:0] st;
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_data = 8'h12;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 2) exp_sh[1] = 8'h12;
      if (k == 8) exp_sh[2] = 8'h07;
      low = (k <= 5) ? 1 : (k == 6) ? -1 : (k <= 11) ? 2 : -1;
      st  = (k == 1 || k == 7) ? 3'd4 : (k == 6 || k == 12) ? 3'd3 : 3'd5;
      n_checks++;
      if (state !== st || cfg_ready !== (k == 6 || k == 12) || tech_cfg !== exp_tc(1'b1, 1'b1, low))
        $display("FAIL b2b k=%0d state=%0d want %0d ready=%0b tech=%h want %h",
                 k, state, st, cfg_ready, tech_cfg, exp_tc(1'b1, 1'b1, low));
      else n_pass++;
      if (k == 1) begin cfg_ch = 3'd2; cfg_data = 8'h07; end
      if (k == 7) cfg_valid = 1'b0;
    end
  endtask

  task automatic test_bad_ch();
    logic [2:0] codes [2];
    codes[0] = 3'd6; codes[1] = 3'd7;
    for (int j = 0; j < 2; j++) begin
      cfg_valid = 1'b1; cfg_ch = codes[j]; cfg_data = 8'hFF;
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL badch_ready ch=%0d got %b want 1", codes[j], cfg_ready);
      else n_pass++;
      step();
      cfg_valid = 1'b0;
      step();
      n_checks++;
      if (state !== 3'd3 || busy !== 1'b0 || tech_cfg !== exp_tc(1'b1, 1'b1, -1))
        $display("FAIL badch ch=%0d state=%0d busy=%0b tech=%h want state=3 tech=%h",
                 codes[j], state, busy, tech_cfg, exp_tc(1'b1, 1'b1, -1));
      else n_pass++;
    end
  endtask

  task automatic test_pwr_loss();
    cfg_valid = 1'b1; cfg_ch = 3'd4; cfg_data = 8'h40;
    step();
    cfg_valid = 1'b0;
    step();
    exp_sh[4] = 8'h40;
    n_checks++;
    if (state !== 3'd5) $display("FAIL loss_pre state got %0d want 5", state);
    else n_pass++;
    pwr_good = 1'b0;
    step();
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b1 || cfg_ready !== 1'b1 || tech_cfg !== exp_tc(1'b0, 1'b0, -1))
      $display("FAIL loss_off state=%0d busy=%0b ready=%0b tech=%h want tech=%h",
               state, busy, cfg_ready, tech_cfg, exp_tc(1'b0, 1'b0, -1));
    else n_pass++;
    n_checks++;
    if (tech_cfg[79:64] !== 16'h0400) $display("FAIL loss_ch4_word got %h want 0400", tech_cfg[79:64]);
    else n_pass++;
  endtask

  task automatic test_off_write();
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_data = 8'hA5;
    step();
    cfg_valid = 1'b0;
    exp_sh[0] = 8'hA5;
    n_checks++;
    if (tech_cfg[15:0] !== 16'hB040 || state !== 3'd0) $display("FAIL offwr_ch0 got %h state %0d want b040 state 0", tech_cfg[15:0], state);
    else n_pass++;
`ifdef GPIO_BANK_CTRL_READBACK_EN
    rd_ch = 3'd0; #1;
    n_checks++;
    if (rd_data !== 8'hA5) $display("FAIL readback_ch0 got %h want a5", rd_data);
    else n_pass++;
    rd_ch = 3'd7; #1;
    n_checks++;
    if (rd_data !== 8'h00) $display("FAIL readback_oob got %h want 00", rd_data);
    else n_pass++;
    rd_ch = 3'd0;
`endif
    cfg_valid = 1'b1; cfg_ch = 3'd6; cfg_data = 8'hFF;
    step();
    cfg_valid = 1'b0;
    n_checks++;
    if (tech_cfg !== exp_tc(1'b0, 1'b0, -1) || state !== 3'd0)
      $display("FAIL offwr_oob tech=%h want %h state=%0d", tech_cfg, exp_tc(1'b0, 1'b0, -1), state);
    else n_pass++;
  endtask

  task automatic test_pwr_priority();
    test_powerup();
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_data = 8'h80;
    step();
    cfg_valid = 1'b0; pwr_good = 1'b0;
    step();
    n_checks++;
    if (state !== 3'd0 || tech_cfg !== exp_tc(1'b0, 1'b0, -1))
      $display("FAIL drop_in_hold state=%0d tech=%h want state=0 tech=%h", state, tech_cfg, exp_tc(1'b0, 1'b0, -1));
    else n_pass++;
    pwr_good = 1'b1;
    step();
    n_checks++;
    if (state !== 3'd1) $display("FAIL prio_wait state got %0d want 1", state);
    else n_pass++;
    pwr_good = 1'b0; cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_data = 8'hFF;
    step();
    n_checks++;
    if (state !== 3'd0 || tech_cfg !== exp_tc(1'b0, 1'b0, -1))
      $display("FAIL prio_write_ignored state=%0d tech=%h want state=0 tech=%h", state, tech_cfg, exp_tc(1'b0, 1'b0, -1));
    else n_pass++;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    pwr_good = 1'b1;
    step();
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_data = 8'h3C;
    step();
    cfg_valid = 1'b0;
    exp_sh[2] = 8'h3C;
    n_checks++;
    if (state !== 3'd1 || tech_cfg !== exp_tc(1'b0, 1'b0, -1))
      $display("FAIL waitwr state=%0d tech=%h want state=1 tech=%h", state, tech_cfg, exp_tc(1'b0, 1'b0, -1));
    else n_pass++;
    reset = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_data = 8'hFF;
    step();
    cfg_valid = 1'b0;
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b1 || tech_cfg !== {6{16'h2000}})
      $display("FAIL reset_mid state=%0d busy=%0b tech=%h want state=0 busy=1 tech=%h", state, busy, tech_cfg, {6{16'h2000}});
    else n_pass++;
    reset = 1'b0;
    step();
    n_checks++;
    if (state !== 3'd1) $display("FAIL reset_release state got %0d want 1", state);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; pwr_good = 1'b0; cfg_valid = 1'b0; cfg_ch = 3'd0; cfg_data = 8'h00;
`ifdef GPIO_BANK_CTRL_READBACK_EN
    rd_ch = 3'd0;
`endif
    @(negedge clk);
    test_reset();
    test_powerup();
    test_update();
    test_back_to_back();
    test_bad_ch();
    test_pwr_loss();
    test_off_write();
    test_pwr_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
